// File: rtl/l_stf_stream_gen_pkg.sv
// Shared constants for the L-STF generator: the full-scale 16-entry base table
// ({I,Q}, 16 bits each) and helpers that split a packed table entry.
package l_stf_stream_gen_pkg;

  localparam int L_STF_PERIOD = 16;

  // Entry n sits at bits [32*n +: 32]; the literal list runs from address 15 down to 0.
  localparam logic [15:0][31:0] L_STF_BASE = {
    32'h004DEF0C, 32'hF5F3FE47, 32'hFE611246, 32'h00000BC7,
    32'hFE611246, 32'hF5F3FE47, 32'h004DEF0C, 32'h05E305E3,
    32'hEF0C004D, 32'hFE47F5F3, 32'h1246FE61, 32'h0BC70000,
    32'h1246FE61, 32'hFE47F5F3, 32'hEF0C004D, 32'h05E305E3
  };

  function automatic logic [15:0] iq_i(input logic [31:0] iq);
    return iq[31:16];
  endfunction

  function automatic logic [15:0] iq_q(input logic [31:0] iq);
    return iq[15:0];
  endfunction

endpackage

// File: rtl/l_stf_base_table.sv
// Full-scale L-STF base table: 4-bit period address to packed 16-bit {I,Q} entry.
module l_stf_base_table
  import l_stf_stream_gen_pkg::*;
(
  input  logic [3:0]  addr,
  output logic [31:0] iq
);

  assign iq = L_STF_BASE[addr];

endmodule

// File: rtl/l_stf_stream_gen.sv
// L-STF burst generator: streams N_REP periods of the short training field over
// valid/ready, scaled by an attenuation shift latched at start.
module l_stf_stream_gen
  import l_stf_stream_gen_pkg::*;
#(
  parameter int IQ_WIDTH  = 16,
  parameter int N_REP     = 10,
  parameter int ATTEN_W   = 2,
  parameter int WINDOW_EN = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ATTEN_W-1:0]    atten,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [2*IQ_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int N_SAMP = L_STF_PERIOD * N_REP;
  localparam int CNT_W  = $clog2(N_SAMP);
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N_SAMP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                 state_r;
  logic [CNT_W-1:0]           k_r;
  logic [ATTEN_W-1:0]         atten_r;
  logic [CNT_W-1:0]           idx_s;
  logic [ATTEN_W-1:0]         atten_sel_s;
  logic                       win_s;
  logic [ATTEN_W:0]           shift_s;
  logic [31:0]                base_s;
  logic signed [IQ_WIDTH-1:0] i_full_s;
  logic signed [IQ_WIDTH-1:0] q_full_s;
  logic signed [IQ_WIDTH-1:0] i_s;
  logic signed [IQ_WIDTH-1:0] q_s;
  logic                       hs_s;

  assign hs_s = m_valid & m_ready;

  // Index and shift of the sample to be loaded next: sample 0 on start, else k+1.
  always_comb begin
    idx_s       = {CNT_W{1'b0}};
    atten_sel_s = atten_r;
    if (state_r == S_IDLE) begin
      idx_s       = {CNT_W{1'b0}};
      atten_sel_s = atten;
    end else begin
      idx_s       = k_r + CNT_W'(1);
      atten_sel_s = atten_r;
    end
  end

  assign win_s   = (WINDOW_EN != 0) && (idx_s == {CNT_W{1'b0}});
  assign shift_s = {1'b0, atten_sel_s} + {{ATTEN_W{1'b0}}, win_s};

  l_stf_base_table u_table (
    .addr (idx_s[3:0]),
    .iq   (base_s)
  );

  // Left-align the sign-extended entry, then floor-scale with an arithmetic shift.
  always_comb begin
    i_full_s = IQ_WIDTH'(signed'(iq_i(base_s)));
    q_full_s = IQ_WIDTH'(signed'(iq_q(base_s)));
    i_s      = (i_full_s <<< (IQ_WIDTH - 16)) >>> shift_s;
    q_s      = (q_full_s <<< (IQ_WIDTH - 16)) >>> shift_s;
  end

  // Burst FSM, sample counter and registered output stage; abort beats handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= S_IDLE;
      k_r     <= {CNT_W{1'b0}};
      atten_r <= {ATTEN_W{1'b0}};
      m_valid <= 1'b0;
      m_data  <= {(2*IQ_WIDTH){1'b0}};
      m_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r <= S_RUN;
            k_r     <= {CNT_W{1'b0}};
            atten_r <= atten;
            m_valid <= 1'b1;
            m_data  <= {i_s, q_s};
            m_last  <= (idx_s == LAST_K);
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_r <= S_IDLE;
            k_r     <= {CNT_W{1'b0}};
            m_valid <= 1'b0;
            m_data  <= {(2*IQ_WIDTH){1'b0}};
            m_last  <= 1'b0;
            busy    <= 1'b0;
          end else if (hs_s) begin
            if (k_r == LAST_K) begin
              state_r <= S_DONE;
              k_r     <= {CNT_W{1'b0}};
              m_valid <= 1'b0;
              m_data  <= {(2*IQ_WIDTH){1'b0}};
              m_last  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              k_r     <= idx_s;
              m_data  <= {i_s, q_s};
              m_last  <= (idx_s == LAST_K);
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          m_valid <= 1'b0;
          m_last  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l_stf_stream_gen.sv
// Directed bench for l_stf_stream_gen: three instances (16-bit plain, 16-bit
// windowed, 18-bit plain) share one stimulus; expected samples are hand-derived.
module tb_l_stf_stream_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  atten = 2'd0;
  logic        m_ready = 1'b1;

  logic        a_valid, a_last, a_busy, a_done;
  logic [31:0] a_data;
  logic        b_valid, b_last, b_busy, b_done;
  logic [31:0] b_data;
  logic        c_valid, c_last, c_busy, c_done;
  logic [35:0] c_data;

  int n_tests = 0;
  int n_fail  = 0;

  int          n_hs, n_done, bad_ctl, stall_bad;
  logic        fin_ok, b_done_end, c_done_end;
  logic [31:0] seen [160];
  logic [31:0] seen_b [2];
  logic [35:0] seen_c [2];
  int          late_done;

  always #5 clk = ~clk;

  l_stf_stream_gen #(.IQ_WIDTH(16), .N_REP(10), .ATTEN_W(2), .WINDOW_EN(0)) dut_a (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .atten(atten),
    .m_valid(a_valid), .m_ready(m_ready), .m_data(a_data), .m_last(a_last),
    .busy(a_busy), .done(a_done)
  );

  l_stf_stream_gen #(.IQ_WIDTH(16), .N_REP(10), .ATTEN_W(2), .WINDOW_EN(1)) dut_b (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .atten(atten),
    .m_valid(b_valid), .m_ready(m_ready), .m_data(b_data), .m_last(b_last),
    .busy(b_busy), .done(b_done)
  );

  l_stf_stream_gen #(.IQ_WIDTH(18), .N_REP(10), .ATTEN_W(2), .WINDOW_EN(0)) dut_c (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .atten(atten),
    .m_valid(c_valid), .m_ready(m_ready), .m_data(c_data), .m_last(c_last),
    .busy(c_busy), .done(c_done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [1:0] att);
    atten = att;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Walks one burst from the first presented sample until busy and valid drop.
  task automatic burst(input logic [1:0] att_run, input int abort_k, input int stall_k,
                       input bit poke_start);
    int   stalled;
    logic v, exp_last;
    stalled = 0;
    n_hs = 0; n_done = 0; bad_ctl = 0; stall_bad = 0;
    fin_ok = 1'b0; b_done_end = 1'b0; c_done_end = 1'b0;
    atten = att_run;
    for (int cyc = 0; cyc < 600 && !fin_ok; cyc++) begin
      if (a_done) n_done++;
      if (!a_valid && !a_busy) begin
        fin_ok     = 1'b1;
        b_done_end = b_done;
        c_done_end = c_done;
      end else begin
        exp_last = (n_hs == 159);
        v = a_valid;
        if (a_valid) begin
          if (a_last !== exp_last || b_last !== exp_last || c_last !== exp_last ||
              b_valid !== 1'b1 || c_valid !== 1'b1 || b_busy !== 1'b1 || c_busy !== 1'b1)
            bad_ctl++;
          if (n_hs < 160) seen[n_hs] = a_data;
          if (n_hs < 2) begin
            seen_b[n_hs] = b_data;
            seen_c[n_hs] = c_data;
          end
        end
        m_ready = 1'b1;
        if (n_hs == stall_k && stalled < 3) begin
          m_ready = 1'b0;
          stalled++;
          if (a_data !== 32'h1246FE61) stall_bad++;
        end
        abort = (n_hs == abort_k);
        start = poke_start && cyc[0];
        step();
        if (v && m_ready && !abort) n_hs++;
      end
    end
    abort = 1'b0; start = 1'b0; m_ready = 1'b1;
    chk("burst_end", {63'd0, fin_ok}, 64'd1);
  endtask

  initial begin
    #12;
    chk("rst_valid", {63'd0, a_valid}, 64'd0);
    chk("rst_data",  {32'd0, a_data},  64'd0);
    chk("rst_last",  {63'd0, a_last},  64'd0);
    chk("rst_busy",  {63'd0, a_busy},  64'd0);
    chk("rst_done",  {63'd0, a_done},  64'd0);
    rstn = 1'b1;
    step();

    // Plain full-scale burst, all three flavours.
    kick(2'd0);
    chk("t1_valid0", {63'd0, a_valid}, 64'd1);
    chk("t1_busy0",  {63'd0, a_busy},  64'd1);
    burst(2'd0, -1, -1, 1'b0);
    chk("t1_done",    {63'd0, a_done}, 64'd1);
    chk("t1_ndone",   64'(n_done), 64'd1);
    chk("t1_busy_end", {63'd0, a_busy}, 64'd0);
    chk("t1_nhs",     64'(n_hs), 64'd160);
    chk("t1_ctl",     64'(bad_ctl), 64'd0);
    chk("t1_k0",      {32'd0, seen[0]},   64'h05E305E3);
    chk("t1_k1",      {32'd0, seen[1]},   64'hEF0C004D);
    chk("t1_k16",     {32'd0, seen[16]},  64'h05E305E3);
    chk("t1_k159",    {32'd0, seen[159]}, 64'h004DEF0C);
    chk("t2_win_k0",  {32'd0, seen_b[0]}, 64'h02F102F1);
    chk("t2_win_k1",  {32'd0, seen_b[1]}, 64'hEF0C004D);
    chk("t6_w18_k0",  {28'd0, seen_c[0]}, {28'd0, 18'h0178C, 18'h0178C});
    chk("t6_w18_k1",  {28'd0, seen_c[1]}, {28'd0, 18'h3BC30, 18'h00134});
    chk("t1_b_done",  {63'd0, b_done_end}, 64'd1);
    chk("t1_c_done",  {63'd0, c_done_end}, 64'd1);
    step();
    chk("t1_done_1cyc", {63'd0, a_done}, 64'd0);

    // Attenuation 2, changed to 0 mid-burst.
    kick(2'd2);
    burst(2'd0, -1, -1, 1'b0);
    chk("t3_k0",     {32'd0, seen[0]},   64'h01780178);
    chk("t3_k1",     {32'd0, seen[1]},   64'hFBC30013);
    chk("t3_k17",    {32'd0, seen[17]},  64'hFBC30013);
    chk("t3_win_k0", {32'd0, seen_b[0]}, 64'h00BC00BC);
    chk("t3_nhs",    64'(n_hs), 64'd160);
    step();

    // Back-pressure for three cycles on k=3.
    kick(2'd0);
    burst(2'd0, -1, 3, 1'b0);
    chk("t4_hold",  64'(stall_bad), 64'd0);
    chk("t4_k3",    {32'd0, seen[3]}, 64'h1246FE61);
    chk("t4_k4",    {32'd0, seen[4]}, 64'h0BC70000);
    chk("t4_nhs",   64'(n_hs), 64'd160);
    chk("t4_ndone", 64'(n_done), 64'd1);
    step();

    // Abort on the k=50 handshake, then restart.
    kick(2'd0);
    burst(2'd0, 50, -1, 1'b0);
    chk("t5_nhs",   64'(n_hs), 64'd50);
    chk("t5_valid", {63'd0, a_valid}, 64'd0);
    chk("t5_busy",  {63'd0, a_busy},  64'd0);
    late_done = n_done;
    for (int i = 0; i < 3; i++) begin
      step();
      if (a_done) late_done++;
    end
    chk("t5_nodone", 64'(late_done), 64'd0);
    kick(2'd0);
    chk("t5_restart_k0", {32'd0, a_data}, 64'h05E305E3);
    burst(2'd0, -1, -1, 1'b0);
    chk("t5_restart_nhs", 64'(n_hs), 64'd160);

    // Start pulses during the burst and coincident with done are ignored.
    step();
    kick(2'd0);
    burst(2'd0, -1, -1, 1'b1);
    chk("t6_nhs",   64'(n_hs), 64'd160);
    chk("t6_k16",   {32'd0, seen[16]}, 64'h05E305E3);
    chk("t6_ndone", 64'(n_done), 64'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_start_at_done_busy",  {63'd0, a_busy},  64'd0);
    chk("t6_start_at_done_valid", {63'd0, a_valid}, 64'd0);

    // Asynchronous reset while k=80 is presented.
    step();
    kick(2'd0);
    repeat (80) step();
    chk("t6_k80", {32'd0, a_data}, 64'h05E305E3);
    #2 rstn = 1'b0;
    #1;
    chk("t6_arst_valid", {63'd0, a_valid}, 64'd0);
    chk("t6_arst_data",  {32'd0, a_data},  64'd0);
    chk("t6_arst_busy",  {63'd0, a_busy},  64'd0);
    chk("t6_arst_last",  {63'd0, a_last},  64'd0);
    chk("t6_arst_cdata", {28'd0, c_data},  64'd0);
    rstn = 1'b1;
    late_done = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (a_done || a_busy || a_valid) late_done++;
    end
    chk("t6_arst_quiet", 64'(late_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
